// File: rtl/if_pc_gen.sv
// Instruction-fetch PC generator: boot sequencing, sequential fetch,
// jump redirect (overrides stall), stall hold and a fetch counter.
module if_pc_gen #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RST_ADDR   = '0,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jump_en_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  pipeline_stall_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  rom_ce_o,
  output logic                  misalign_o,
  output logic [CNT_WIDTH-1:0]  fetch_cnt_o
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [ADDR_WIDTH-1:0] pc_d;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic                  mis_d;
  logic                  ce_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Jump wins over stall so a redirect is never dropped.
  always_comb begin
    pc_d  = pc_o;
    cnt_d = fetch_cnt_o;
    mis_d = 1'b0;
    ce_d  = (state_d == RUN);
    if (state_q == RUN) begin
      unique case (1'b1)
        jump_en_i: begin
          pc_d  = {jump_addr_i[ADDR_WIDTH-1:2], 2'b00};
          cnt_d = fetch_cnt_o + CNT_WIDTH'(1);
          mis_d = |jump_addr_i[1:0];
        end
        (!jump_en_i && pipeline_stall_i): begin
          pc_d = pc_o;
        end
        default: begin
          pc_d  = pc_o + ADDR_WIDTH'(4);
          cnt_d = fetch_cnt_o + CNT_WIDTH'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_o        <= RST_ADDR;
      rom_ce_o    <= 1'b0;
      misalign_o  <= 1'b0;
      fetch_cnt_o <= '0;
    end else begin
      pc_o        <= pc_d;
      rom_ce_o    <= ce_d;
      misalign_o  <= mis_d;
      fetch_cnt_o <= cnt_d;
    end
  end

endmodule
